// File: rtl/hack_alu_pkg.sv
// ---------------------------------------------------------------------------
// hack_alu_pkg
// Shared definitions for the pipelined Hack ALU:
//   - bit positions of the six control bits inside the 6-bit op field
//   - named opcodes for the common Hack ALU operations
// No ports; imported by hack_alu_core and hack_alu_pipe.
// ---------------------------------------------------------------------------
package hack_alu_pkg;

    // Control bit positions within op[5:0]
    localparam int OP_ZX = 0;  // zero x
    localparam int OP_NX = 1;  // invert x (after zx)
    localparam int OP_ZY = 2;  // zero y
    localparam int OP_NY = 3;  // invert y (after zy)
    localparam int OP_F  = 4;  // 1: add, 0: and
    localparam int OP_NO = 5;  // invert the function output

    // Named opcodes, encoded {no, f, ny, zy, nx, zx}
    localparam logic [5:0] OP_ZERO = 6'b010101;
    localparam logic [5:0] OP_ONE  = 6'b111111;
    localparam logic [5:0] OP_NEG1 = 6'b010111;
    localparam logic [5:0] OP_X    = 6'b001100;
    localparam logic [5:0] OP_Y    = 6'b000011;
    localparam logic [5:0] OP_NOTX = 6'b101100;
    localparam logic [5:0] OP_NEGX = 6'b111100;
    localparam logic [5:0] OP_XP1  = 6'b111110;
    localparam logic [5:0] OP_XM1  = 6'b011100;
    localparam logic [5:0] OP_XPY  = 6'b010000;

endpackage

// File: rtl/hack_alu_core.sv
// ---------------------------------------------------------------------------
// hack_alu_core
// Purely combinational function stage of the Hack ALU. Takes the already
// preset operands (x', y') and produces the final result plus flags.
// Ports:
//   x_i, y_i   in  WIDTH  preset operands x', y'
//   f_i        in  1      1: x'+y', 0: x'&y'
//   no_i       in  1      invert the function output
//   result_o   out WIDTH  final result
//   zr_o       out 1      result == 0
//   ng_o       out 1      result msb
//   co_o       out 1      carry out of x'+y' (0 for the AND function)
//   ov_o       out 1      signed overflow of x'+y' before inversion (0 for AND)
// ---------------------------------------------------------------------------
module hack_alu_core #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] x_i,
    input  logic [WIDTH-1:0] y_i,
    input  logic             f_i,
    input  logic             no_i,
    output logic [WIDTH-1:0] result_o,
    output logic             zr_o,
    output logic             ng_o,
    output logic             co_o,
    output logic             ov_o
);

    logic [WIDTH:0]   sum;
    logic [WIDTH-1:0] func;

    always_comb begin
        // One extra bit on the adder so the carry comes out for free
        sum      = {1'b0, x_i} + {1'b0, y_i};
        func     = f_i ? sum[WIDTH-1:0] : (x_i & y_i);
        result_o = no_i ? ~func : func;
        zr_o     = (result_o == '0);
        ng_o     = result_o[WIDTH-1];
        co_o     = f_i & sum[WIDTH];
        // Overflow: operands share a sign but the sum's sign differs.
        // Taken from the raw sum, so the no inversion never affects it.
        ov_o     = f_i & (x_i[WIDTH-1] == y_i[WIDTH-1])
                       & (sum[WIDTH-1] != x_i[WIDTH-1]);
    end

endmodule

// File: rtl/hack_alu_pipe.sv
// ---------------------------------------------------------------------------
// hack_alu_pipe
// Two-stage pipelined Hack ALU with carry/overflow flags and valid/ready
// handshakes on both sides.
//   Stage 1 registers the preset operands x', y' together with f and no.
//   Stage 2 registers the output of hack_alu_core (result and flags); these
//   registers drive the outputs directly.
// Ports:
//   clk        in  1      rising-edge clock
//   rst_n      in  1      asynchronous active-low reset
//   in_valid   in  1      operands/op presented
//   in_ready   out 1      stage 1 can accept this cycle
//   x, y       in  WIDTH  operands
//   op         in  6      {no, f, ny, zy, nx, zx}
//   out_valid  out 1      result/flags valid
//   out_ready  in  1      consumer accepts result
//   result     out WIDTH  ALU output
//   zr, ng     out 1      zero / negative flags of result
//   co, ov     out 1      carry / signed overflow of x'+y' (0 when f=0)
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// in_ready depends only on pipeline state and out_ready, never on in_valid.
// While out_valid && !out_ready the outputs stay frozen. A stage moves
// forward whenever the stage ahead is empty or emptying in the same cycle,
// so accept, s1->s2 move and output pop can all happen in one cycle.
// With out_valid=0 the result/flag registers keep their last values.
// ---------------------------------------------------------------------------
module hack_alu_pipe
    import hack_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [5:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zr,
    output logic             ng,
    output logic             co,
    output logic             ov
);

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_x_q,     s1_x_d;
    logic [WIDTH-1:0] s1_y_q,     s1_y_d;
    logic             s1_f_q,     s1_f_d;
    logic             s1_no_q,    s1_no_d;

    // Stage 2 registers (these are the outputs)
    logic             s2_valid_q,  s2_valid_d;
    logic [WIDTH-1:0] s2_result_q, s2_result_d;
    logic             s2_zr_q,     s2_zr_d;
    logic             s2_ng_q,     s2_ng_d;
    logic             s2_co_q,     s2_co_d;
    logic             s2_ov_q,     s2_ov_d;

    // Preset operands and core outputs
    logic [WIDTH-1:0] x_pre, y_pre;
    logic [WIDTH-1:0] core_result;
    logic             core_zr, core_ng, core_co, core_ov;

    // Handshake terms
    logic adv2;     // stage 2 can take a new entry this cycle
    logic accept;   // input transfer
    logic move;     // stage 1 -> stage 2 transfer

    always_comb begin
        adv2     = !s2_valid_q || out_ready;
        in_ready = !s1_valid_q || adv2;
        accept   = in_valid && in_ready;
        move     = s1_valid_q && adv2;
    end

    // Zero first, then invert, as in the original Hack ALU
    always_comb begin
        x_pre = op[OP_ZX] ? '0 : x;
        if (op[OP_NX]) begin
            x_pre = ~x_pre;
        end
        y_pre = op[OP_ZY] ? '0 : y;
        if (op[OP_NY]) begin
            y_pre = ~y_pre;
        end
    end

    hack_alu_core #(
        .WIDTH(WIDTH)
    ) u_core (
        .x_i     (s1_x_q),
        .y_i     (s1_y_q),
        .f_i     (s1_f_q),
        .no_i    (s1_no_q),
        .result_o(core_result),
        .zr_o    (core_zr),
        .ng_o    (core_ng),
        .co_o    (core_co),
        .ov_o    (core_ov)
    );

    // Stage 1 next state
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_x_d     = s1_x_q;
        s1_y_d     = s1_y_q;
        s1_f_d     = s1_f_q;
        s1_no_d    = s1_no_q;
        // When stage 1 is free (empty or handing off) it takes whatever is
        // offered, including nothing, which leaves a bubble.
        if (in_ready) begin
            s1_valid_d = in_valid;
        end
        if (accept) begin
            s1_x_d  = x_pre;
            s1_y_d  = y_pre;
            s1_f_d  = op[OP_F];
            s1_no_d = op[OP_NO];
        end
    end

    // Stage 2 next state
    always_comb begin
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_zr_d     = s2_zr_q;
        s2_ng_d     = s2_ng_q;
        s2_co_d     = s2_co_q;
        s2_ov_d     = s2_ov_q;
        if (adv2) begin
            s2_valid_d = s1_valid_q;
        end
        // Data only changes on a real move, so result/flags keep their
        // last values whenever out_valid is low or the consumer stalls.
        if (move) begin
            s2_result_d = core_result;
            s2_zr_d     = core_zr;
            s2_ng_d     = core_ng;
            s2_co_d     = core_co;
            s2_ov_d     = core_ov;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            s1_x_q      <= '0;
            s1_y_q      <= '0;
            s1_f_q      <= 1'b0;
            s1_no_q     <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zr_q     <= 1'b0;
            s2_ng_q     <= 1'b0;
            s2_co_q     <= 1'b0;
            s2_ov_q     <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_x_q      <= s1_x_d;
            s1_y_q      <= s1_y_d;
            s1_f_q      <= s1_f_d;
            s1_no_q     <= s1_no_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zr_q     <= s2_zr_d;
            s2_ng_q     <= s2_ng_d;
            s2_co_q     <= s2_co_d;
            s2_ov_q     <= s2_ov_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = s2_result_q;
    assign zr        = s2_zr_q;
    assign ng        = s2_ng_q;
    assign co        = s2_co_q;
    assign ov        = s2_ov_q;

endmodule
